sccb_arbiter: RTL
=================

Name: sccb_arbiter

Overview:
- Shares one SCCB/I2C byte engine between NUM_REQ requesters, e.g. the camera init-ROM sequencer and a runtime register-tweak port for exposure or gain.
- Drives the engine's byte interface: strobe, data byte, last-byte flag, and busy return.
- Grants the engine round-robin for one whole multi-byte transaction at a time, so transactions never interleave on the bus.

Parameters:
- NUM_REQ, 2, number of requesters (2..4).
- BUSY_TIMEOUT, 64, watchdog limit in clk cycles for busy to rise after a strobe (used only with the optional feature).

Ports:
- clk  input  1  system clock (50 MHz).
- reset  input  1  asynchronous, active-high reset.
- req  input  NUM_REQ  per-requester valid; high while a byte is presented.
- req_data  input  8*NUM_REQ  byte from requester i at bits [8i+7:8i].
- req_last  input  NUM_REQ  presented byte is the final byte of the transaction.
- ack  output  NUM_REQ  one-cycle pulse; presented byte has been taken.
- grant  output  NUM_REQ  one-hot; requester owns the engine.
- done  output  NUM_REQ  one-cycle pulse; transaction has finished on the bus.
- i2c_strobe  output  1  one-cycle pulse; starts a byte in the engine.
- i2c_data  output  8  byte to the engine; held from the strobe until the next strobe.
- i2c_last  output  1  last-byte flag to the engine; held like i2c_data.
- i2c_busy  input  1  engine busy.
- err  output  1  one-cycle pulse; watchdog fired (optional feature only, otherwise tied 0).

Behaviour:
- Reset values:
  - All outputs 0.
  - State IDLE.
  - Round-robin pointer last_grant = NUM_REQ-1, so requester 0 has first priority.
- All outputs are registered.
- State IDLE:
  - If any req is high, select the first requester scanning from last_grant+1 with wrap-around.
  - Next edge: grant[sel] goes to 1, last_grant becomes sel, state goes to ISSUE.
  - If no req is high, stay in IDLE.
- State ISSUE:
  - If req[g] is low, wait with no timeout and keep grant held.
  - If req[g] is high, next edge: i2c_strobe=1 and ack[g]=1 for exactly one cycle; i2c_data<=req_data[g]; i2c_last<=req_last[g]; state goes to WAIT_RISE.
- State WAIT_RISE: when i2c_busy is 1, go to WAIT_FALL.
- State WAIT_FALL:
  - Wait for i2c_busy to be 0.
  - If i2c_last=1: next edge done[g]=1 for one cycle, grant cleared, state goes to IDLE.
  - Otherwise go back to ISSUE for the next byte.
- Latency, from req rising in IDLE to i2c_strobe: 2 cycles.
- Gap between successive bytes of one transaction: 2 cycles after busy falls.
- Requirement on requesters: after an ack, the requester presents its next byte, or drops req, before the arbiter re-enters ISSUE. ISSUE is reached at least 3 cycles after the ack.
- Grant stability:
  - A grant is never revoked mid-transaction, regardless of other req activity.
  - Requests arriving during a transaction are held off until IDLE.
- Simultaneous requests: arbitration is strict round-robin, so every requester is served within NUM_REQ transactions.
- A requester that requests again immediately after its done loses to any other pending requester.
- i2c_busy already high in IDLE (engine busy from elsewhere): no strobe is issued; the arbiter waits in ISSUE → WAIT_RISE ordering as normal. The first strobe comes only from ISSUE.
- Reset mid-transaction:
  - Immediate return to IDLE with all outputs 0.
  - The engine shares the same reset.
- At most one ack, done and strobe is high in any cycle; ack and strobe are always coincident.

Optional Feature:
- Macro: SCCB_ARBITER_TIMEOUT_EN.
- When defined:
  - A counter clears on entry to WAIT_RISE and increments each cycle.
  - If it reaches BUSY_TIMEOUT with i2c_busy still 0: err=1 for one cycle, grant cleared, no done pulse, state goes to IDLE, last_grant unchanged.
- When undefined:
  - WAIT_RISE waits indefinitely.
  - err is tied to 0.
  - No counter logic exists.

Test Plan:
- Single transaction:
  - Stimulus: req[0] presents 0x42, 0x11, then 0x80 with last=1; engine model busy for 20 cycles per byte.
  - Required: 3 strobes carrying i2c_data 0x42, 0x11, 0x80; i2c_last=1 only on the third; done[0] pulses once; grant[0] falls with it.
- Simultaneous requests:
  - Stimulus: req[0] and req[1] rise in the same cycle right after reset.
  - Required: requester 0 is served first, then requester 1; the second strobe of requester 1 never precedes done[0].
- Fairness:
  - Stimulus: both requesters issue back-to-back single-byte transactions continuously.
  - Required: grants alternate 0,1,0,1 over 8 transactions.
- Stalled requester:
  - Stimulus: requester 0 drops req for 50 cycles between bytes while req[1] is high.
  - Required: grant[0] held throughout; no strobe during the stall; requester 1 served only after done[0].
- Reset mid-transaction:
  - Stimulus: assert reset while in WAIT_FALL.
  - Required: all outputs 0 within the reset cycle; after release, req[0] yields a strobe 2 cycles later.
- Watchdog (SCCB_ARBITER_TIMEOUT_EN, BUSY_TIMEOUT=64):
  - Stimulus: engine model never raises busy.
  - Required: err pulses 64 cycles after the strobe; grant clears; no done pulse.

Source files
------------

// File: rtl/sccb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sccb_arbiter
// Purpose  : Round-robin arbiter that shares one SCCB/I2C byte engine between
//            NUM_REQ requesters. The owner keeps the engine for a whole
//            multi-byte transaction, so transactions never interleave.
// Options  : define SCCB_ARBITER_TIMEOUT_EN to add a watchdog that aborts a
//            transaction when busy fails to rise within BUSY_TIMEOUT cycles.
// Revision : 1.0 - initial release
// ============================================================================
module sccb_arbiter #(
  parameter int NUM_REQ      = 2,
  parameter int BUSY_TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_i,
  input  logic [8*NUM_REQ-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]   req_last_i,
  output logic [NUM_REQ-1:0]   ack_o,
  output logic [NUM_REQ-1:0]   grant_o,
  output logic [NUM_REQ-1:0]   done_o,
  output logic                 i2c_strobe_o,
  output logic [7:0]           i2c_data_o,
  output logic                 i2c_last_o,
  input  logic                 i2c_busy_i,
  output logic                 err_o
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_ISSUE     = 2'd1,
    S_WAIT_RISE = 2'd2,
    S_WAIT_FALL = 2'd3
  } state_t;

  state_t             state_q, state_d;
  // last_grant_q doubles as the owner index while a grant is held
  logic [IW-1:0]      last_grant_q, last_grant_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic               strobe_q, strobe_d;
  logic [7:0]         data_q, data_d;
  logic               last_q, last_d;

  logic [IW-1:0]      rr_sel;
  logic               rr_valid;
  logic               own_req;
  logic               own_last;
  logic [7:0]         own_data;

`ifdef SCCB_ARBITER_TIMEOUT_EN
  localparam int CW = $clog2(BUSY_TIMEOUT + 1);
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               err_q, err_d;
  assign err_o = err_q;
`else
  assign err_o = 1'b0;
  // Degenerate timeout values are only meaningful with the watchdog built in
  if (BUSY_TIMEOUT < 2) begin : g_timeout_unused
  end
`endif

  assign ack_o        = ack_q;
  assign grant_o      = grant_q;
  assign done_o       = done_q;
  assign i2c_strobe_o = strobe_q;
  assign i2c_data_o   = data_q;
  assign i2c_last_o   = last_q;

  // Round-robin pick: first active request after last_grant, with wrap-around
  always_comb begin
    rr_valid = 1'b0;
    rr_sel   = last_grant_q;
    // Scan from the farthest offset down so the nearest match wins
    for (int k = NUM_REQ; k >= 1; k--) begin
      for (int j = 0; j < NUM_REQ; j++) begin
        if (req_i[j] && (j == ((int'(last_grant_q) + k) % NUM_REQ))) begin
          rr_valid = 1'b1;
          rr_sel   = IW'(j);
        end
      end
    end
  end

  // Select the owner's valid, byte and last flag
  always_comb begin
    own_req  = 1'b0;
    own_last = 1'b0;
    own_data = 8'h00;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (last_grant_q == IW'(j)) begin
        own_req  = req_i[j];
        own_last = req_last_i[j];
        own_data = req_data_i[8*j +: 8];
      end
    end
  end

  // Next-state and registered-output logic of the transaction FSM
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    ack_d        = '0;
    done_d       = '0;
    strobe_d     = 1'b0;
    data_d       = data_q;
    last_d       = last_q;
`ifdef SCCB_ARBITER_TIMEOUT_EN
    cnt_d        = cnt_q;
    err_d        = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (rr_valid) begin
          grant_d         = '0;
          grant_d[rr_sel] = 1'b1;
          last_grant_d    = rr_sel;
          state_d         = S_ISSUE;
        end
      end
      S_ISSUE: begin
        // A stalled owner keeps the grant indefinitely
        if (own_req) begin
          strobe_d = 1'b1;
          ack_d    = grant_q;
          data_d   = own_data;
          last_d   = own_last;
          state_d  = S_WAIT_RISE;
`ifdef SCCB_ARBITER_TIMEOUT_EN
          cnt_d    = '0;
`endif
        end
      end
      S_WAIT_RISE: begin
        if (i2c_busy_i) begin
          state_d = S_WAIT_FALL;
        end
`ifdef SCCB_ARBITER_TIMEOUT_EN
        else if (cnt_q == CW'(BUSY_TIMEOUT - 1)) begin
          // Abort: no done pulse, round-robin pointer left as is
          err_d   = 1'b1;
          grant_d = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      S_WAIT_FALL: begin
        if (!i2c_busy_i) begin
          if (last_q) begin
            done_d  = grant_q;
            grant_d = '0;
            state_d = S_IDLE;
          end else begin
            state_d = S_ISSUE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers, asynchronously cleared
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      last_grant_q <= IW'(NUM_REQ - 1);
      grant_q      <= '0;
      ack_q        <= '0;
      done_q       <= '0;
      strobe_q     <= 1'b0;
      data_q       <= 8'h00;
      last_q       <= 1'b0;
`ifdef SCCB_ARBITER_TIMEOUT_EN
      cnt_q        <= '0;
      err_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      ack_q        <= ack_d;
      done_q       <= done_d;
      strobe_q     <= strobe_d;
      data_q       <= data_d;
      last_q       <= last_d;
`ifdef SCCB_ARBITER_TIMEOUT_EN
      cnt_q        <= cnt_d;
      err_q        <= err_d;
`endif
    end
  end

endmodule
`default_nettype wire
